// File: rtl/alu_ops_pkg.sv
// Shared ALU operation codes, RV32I opcode constants and the ID/EX pipeline register layout
// for the ALU issue stage.
package alu_ops_pkg;

  localparam int unsigned DW  = 32;
  localparam int unsigned PCW = 9;
  localparam int unsigned RAW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_JAL = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_NE  = 4'b1001;
  localparam logic [3:0] ALU_LT  = 4'b1010;
  localparam logic [3:0] ALU_GE  = 4'b1011;
  localparam logic [3:0] ALU_SLT = 4'b1100;
  localparam logic [3:0] ALU_SUB = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic           valid;
    logic [3:0]     operation;
    logic [DW-1:0]  src_a;
    logic [DW-1:0]  src_b;
    logic [PCW-1:0] pc_cur;
    logic           branch;
    logic [RAW-1:0] rd;
    logic           regwrite;
    logic           memread;
    logic           memwrite;
    logic [DW-1:0]  store_data;
    logic           illegal;
  } id_ex_t;

  // Operand bypass: youngest producer wins; x0 always reads the register file value.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [RAW-1:0] rs,
    input logic [DW-1:0]  rf_data,
    input logic           ex_fwd,
    input logic [RAW-1:0] ex_rd,
    input logic [DW-1:0]  ex_result,
    input logic           mem_we,
    input logic [RAW-1:0] mem_rd,
    input logic [DW-1:0]  mem_result,
    input logic           wb_we,
    input logic [RAW-1:0] wb_rd,
    input logic [DW-1:0]  wb_result
  );
    if (rs == '0) return rf_data;
    if (ex_fwd && ex_rd == rs) return ex_result;
    if (mem_we && mem_rd == rs) return mem_result;
    if (wb_we && wb_rd == rs) return wb_result;
    return rf_data;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I decode into ALU operation, operand selects and memory/writeback controls.
module alu_op_decoder
  import alu_ops_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  op,
  output logic        imm_sel,
  output logic        zero_a,
  output logic        shift,
  output logic        branch,
  output logic        memread,
  output logic        memwrite,
  output logic        writes_rd,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       alt;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign f3           = instr[14:12];
  assign alt          = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    op        = ALU_AND;
    imm_sel   = 1'b0;
    zero_a    = 1'b0;
    shift     = 1'b0;
    branch    = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    illegal   = 1'b0;
    unique case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = (opcode == OPC_OP);
        imm_sel   = (opcode == OPC_OP_IMM);
        // instr[30] is funct7[5] for R-type and imm[10] for I-type shifts
        unique case (f3)
          3'b000: op = (alt && opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
          3'b001: begin op = ALU_SLL; shift = 1'b1; end
          3'b010: op = ALU_SLT;
          3'b100: op = ALU_XOR;
          3'b101: begin op = alt ? ALU_SRA : ALU_SRL; shift = 1'b1; end
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        op = ALU_ADD; imm_sel = 1'b1; memread = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        op = ALU_ADD; imm_sel = 1'b1; memwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        unique case (f3)
          3'b000: op = ALU_EQ;
          3'b001: op = ALU_NE;
          3'b100: op = ALU_LT;
          3'b101: op = ALU_GE;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        op = ALU_JAL; branch = 1'b1; writes_rd = 1'b1;
      end
      OPC_JALR: begin
        op = ALU_JAL; branch = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_LUI: begin
        op = ALU_ADD; imm_sel = 1'b1; zero_a = 1'b1; writes_rd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand forwarding, load-use hazard detection and the ID/EX
// register that feeds the ALU.
module alu_issue_stage
  import alu_ops_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DW,
  parameter int unsigned PC_WIDTH   = PCW,
  parameter int unsigned REG_ADDR   = RAW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [PC_WIDTH-1:0]   id_pc,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [REG_ADDR-1:0]   mem_rd,
  input  logic                  mem_regwrite,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [REG_ADDR-1:0]   wb_rd,
  input  logic                  wb_regwrite,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic                  id_ready,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic [3:0]            ex_operation,
  output logic [DATA_WIDTH-1:0] ex_src_a,
  output logic [DATA_WIDTH-1:0] ex_src_b,
  output logic [PC_WIDTH-1:0]   ex_pc_cur,
  output logic                  ex_branch,
  output logic [REG_ADDR-1:0]   ex_rd,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic                  ex_illegal
);

  logic [3:0]            dec_op;
  logic                  imm_sel, zero_a, shift, dec_branch, dec_memread, dec_memwrite;
  logic                  writes_rd, use_rs1, use_rs2, dec_illegal;
  logic [REG_ADDR-1:0]   rs1, rs2, rd;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b, src_b;
  logic                  ex_fwd;
  id_ex_t                ex_q, ex_d, issue;

  alu_op_decoder u_decoder (
    .instr     (id_instr),
    .op        (dec_op),
    .imm_sel   (imm_sel),
    .zero_a    (zero_a),
    .shift     (shift),
    .branch    (dec_branch),
    .memread   (dec_memread),
    .memwrite  (dec_memwrite),
    .writes_rd (writes_rd),
    .use_rs1   (use_rs1),
    .use_rs2   (use_rs2),
    .illegal   (dec_illegal)
  );

  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign rd  = id_instr[11:7];

  // A load in EX has no data yet; it is covered by the hazard stall, not by bypass.
  assign ex_fwd = ex_q.valid && ex_q.regwrite && !ex_q.memread;

  assign fwd_a = fwd_sel(rs1, id_rs1_data, ex_fwd, ex_q.rd, alu_result, mem_regwrite, mem_rd,
                         mem_result, wb_regwrite, wb_rd, wb_result);
  assign fwd_b = fwd_sel(rs2, id_rs2_data, ex_fwd, ex_q.rd, alu_result, mem_regwrite, mem_rd,
                         mem_result, wb_regwrite, wb_rd, wb_result);

  assign hazard_stall = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                        ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
  assign id_ready     = !hazard_stall && !stall_in;

  always_comb begin
    src_b = imm_sel ? id_imm : fwd_b;
    if (shift) src_b = {{(DATA_WIDTH-5){1'b0}}, src_b[4:0]};

    issue            = '0;
    issue.valid      = 1'b1;
    issue.operation  = dec_op;
    issue.src_a      = zero_a ? '0 : fwd_a;
    issue.src_b      = src_b;
    issue.pc_cur     = id_pc;
    issue.branch     = dec_branch;
    issue.rd         = writes_rd ? rd : '0;
    issue.regwrite   = writes_rd && (rd != '0);
    issue.memread    = dec_memread;
    issue.memwrite   = dec_memwrite;
    issue.store_data = fwd_b;
    if (dec_illegal) begin
      issue         = '0;
      issue.illegal = 1'b1;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall_in) begin
      ex_d = ex_q;
    end else if (hazard_stall || !id_valid) begin
      ex_d = '0;
    end else begin
      ex_d = issue;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_operation  = ex_q.operation;
  assign ex_src_a      = ex_q.src_a;
  assign ex_src_b      = ex_q.src_b;
  assign ex_pc_cur     = ex_q.pc_cur;
  assign ex_branch     = ex_q.branch;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_store_data = ex_q.store_data;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written pipeline
// sequences and randomized traffic against a behavioural model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [8:0]  id_pc;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        stall_in, flush;
  logic [31:0] alu_result;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_regwrite, wb_regwrite;
  logic [31:0] mem_result, wb_result;
  logic        id_ready, hazard_stall;
  logic        ex_valid, ex_branch, ex_regwrite, ex_memread, ex_memwrite, ex_illegal;
  logic [3:0]  ex_operation;
  logic [31:0] ex_src_a, ex_src_b, ex_store_data;
  logic [8:0]  ex_pc_cur;
  logic [4:0]  ex_rd;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .stall_in(stall_in), .flush(flush), .alu_result(alu_result),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .id_ready(id_ready), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_operation(ex_operation), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .ex_pc_cur(ex_pc_cur), .ex_branch(ex_branch), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [8:0]  pc;
    logic        br;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic        ill;
  } ex_t;

  // fl = {valid, regwrite, memread, memwrite, branch, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [5:0]  fl;
  } vec_t;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;

  int   total = 0;
  int   bad = 0;
  ex_t  mdl;
  logic pre_hz, pre_rdy;
  vec_t tbl[15];

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ex_t obs();
    return '{ex_valid, ex_operation, ex_src_a, ex_src_b, ex_pc_cur, ex_branch, ex_rd,
             ex_regwrite, ex_memread, ex_memwrite, ex_store_data, ex_illegal};
  endfunction

  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (mdl.valid && mdl.rw && !mdl.mr && mdl.rd == r) return alu_result;
    if (mem_regwrite && mem_rd == r) return mem_result;
    if (wb_regwrite && wb_rd == r) return wb_result;
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic [6:0] opc;
    logic u1, u2;
    opc = id_instr[6:0];
    u1 = (opc inside {R, I, LD, ST, BR, JR});
    u2 = (opc inside {R, ST, BR});
    return mdl.valid && mdl.mr && mdl.rd != 0 &&
           ((u1 && id_instr[19:15] == mdl.rd) || (u2 && id_instr[24:20] == mdl.rd));
  endfunction

  function automatic ex_t model_issue();
    ex_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic alt, wr, useimm, sh, bad_op;
    logic [4:0] rd;
    opc = id_instr[6:0]; f3 = id_instr[14:12]; alt = id_instr[30]; rd = id_instr[11:7];
    wr = 0; useimm = 0; sh = 0; bad_op = 0;
    e = '0;
    e.valid = 1; e.pc = id_pc;
    e.a = mfwd(id_instr[19:15], id_rs1_data);
    e.b = mfwd(id_instr[24:20], id_rs2_data);
    e.sd = e.b;
    case (opc)
      R, I: begin
        wr = 1; useimm = (opc == I);
        case (f3)
          3'd0: e.op = (alt && !useimm) ? 4'b1111 : 4'b0010;
          3'd1: begin e.op = 4'b0100; sh = 1; end
          3'd2: e.op = 4'b1100;
          3'd4: e.op = 4'b0110;
          3'd5: begin e.op = alt ? 4'b0111 : 4'b0101; sh = 1; end
          3'd6: e.op = 4'b0001;
          3'd7: e.op = 4'b0000;
          default: bad_op = 1;
        endcase
      end
      LD: begin wr = 1; useimm = 1; e.op = 4'b0010; e.mr = 1; end
      ST: begin useimm = 1; e.op = 4'b0010; e.mw = 1; end
      BR: case (f3)
        3'd0: e.op = 4'b1000;
        3'd1: e.op = 4'b1001;
        3'd4: e.op = 4'b1010;
        3'd5: e.op = 4'b1011;
        default: bad_op = 1;
      endcase
      JL, JR: begin wr = 1; e.op = 4'b0011; e.br = 1; end
      LU: begin wr = 1; useimm = 1; e.op = 4'b0010; e.a = 0; end
      default: bad_op = 1;
    endcase
    if (useimm) e.b = id_imm;
    if (sh) e.b = {27'b0, e.b[4:0]};
    if (wr) e.rd = rd;
    e.rw = wr && (rd != 0);
    if (bad_op) begin
      e = '0;
      e.ill = 1;
    end
    return e;
  endfunction

  // One clock: combinational checks before the edge, register checks after it.
  task automatic step();
    ex_t nxt;
    logic hz;
    #1;
    hz = model_hazard();
    pre_hz = hazard_stall;
    pre_rdy = id_ready;
    cmp("hazard_stall", 128'(hazard_stall), 128'(hz));
    cmp("id_ready", 128'(id_ready), 128'(!hz && !stall_in));
    if (flush) nxt = '0;
    else if (stall_in) nxt = mdl;
    else if (hz || !id_valid) nxt = '0;
    else nxt = model_issue();
    @(posedge clk);
    #1;
    mdl = nxt;
    cmp("ex_regs", 128'(obs()), 128'(mdl));
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm);
    id_valid = 1; id_instr = ins; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
  endtask

  task automatic rand_cycle();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [31:0] ins;
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7)); f3 = 3'($urandom);
    case ($urandom_range(0, 9))
      0, 1: ins = {($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0, rs2, rs1, f3, rd, R};
      2, 3: ins = {12'($urandom), rs1, f3, rd, I};
      4: ins = {12'($urandom), rs1, 3'b010, rd, LD};
      5: ins = {7'($urandom), rs2, rs1, 3'b010, 5'($urandom), ST};
      6: ins = {7'($urandom), rs2, rs1, f3, 5'($urandom), BR};
      7: ins = ($urandom_range(0, 1) != 0) ? {20'($urandom), rd, JL}
                                          : {12'($urandom), rs1, 3'b000, rd, JR};
      8: ins = {20'($urandom), rd, LU};
      default: ins = {25'($urandom), ($urandom_range(0, 1) != 0) ? 7'b0001011 : 7'b1110011};
    endcase
    drive(ins, $urandom, $urandom, {{20{ins[31]}}, ins[31:20]});
    id_valid = ($urandom_range(0, 7) != 0);
    id_pc = 9'($urandom);
    alu_result = $urandom; mem_result = $urandom; wb_result = $urandom;
    mem_rd = 5'($urandom_range(0, 7)); wb_rd = 5'($urandom_range(0, 7));
    mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
    flush = ($urandom_range(0, 9) == 0);
    stall_in = ($urandom_range(0, 7) == 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{{7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, R}, 7, 9, 0, 4'hF, 7, 9, 3, 6'b110000};
    tbl[1]  = '{{12'h403, 5'd8, 3'b101, 5'd7, I}, 32'h8000_0000, 0, 32'h403, 4'h7,
                32'h8000_0000, 3, 7, 6'b110000};
    tbl[2]  = '{{7'b0, 5'd2, 5'd1, 3'b101, 5'd0, BR}, 5, 6, 0, 4'hB, 5, 6, 0, 6'b100000};
    tbl[3]  = '{{20'h80000, 5'd1, JL}, 11, 22, 0, 4'h3, 11, 22, 1, 6'b110010};
    tbl[4]  = '{{20'h12345, 5'd9, LU}, 3, 4, 32'h1234_5000, 4'h2, 0, 32'h1234_5000, 9,
                6'b110000};
    tbl[5]  = '{{7'b0, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0001011}, 1, 2, 0, 4'h0, 0, 0, 0,
                6'b000001};
    tbl[6]  = '{{7'b0, 5'd2, 5'd1, 3'b010, 5'd4, ST}, 100, 32'hAB, 4, 4'h2, 100, 4, 0,
                6'b100100};
    tbl[7]  = '{{12'd8, 5'd1, 3'b010, 5'd4, LD}, 200, 0, 8, 4'h2, 200, 8, 4, 6'b111000};
    tbl[8]  = '{{7'b0, 5'd2, 5'd1, 3'b001, 5'd5, R}, 32'hF, 32'h25, 0, 4'h4, 32'hF, 5, 5,
                6'b110000};
    tbl[9]  = '{{7'b0, 5'd2, 5'd1, 3'b110, 5'd0, BR}, 1, 2, 0, 4'h0, 0, 0, 0, 6'b000001};
    tbl[10] = '{{7'b0, 5'd2, 5'd1, 3'b000, 5'd0, R}, 1, 2, 0, 4'h2, 1, 2, 0, 6'b100000};
    tbl[11] = '{{7'b0, 5'd2, 5'd1, 3'b100, 5'd0, BR}, 3, 4, 0, 4'hA, 3, 4, 0, 6'b100000};
    tbl[12] = '{{12'hFFF, 5'd1, 3'b100, 5'd2, I}, 32'hF0F, 0, 32'hFFFF_FFFF, 4'h6, 32'hF0F,
                32'hFFFF_FFFF, 2, 6'b110000};
    tbl[13] = '{{12'd0, 5'd5, 3'b000, 5'd1, JR}, 40, 7, 0, 4'h3, 40, 7, 1, 6'b110010};
    tbl[14] = '{{7'b0100000, 5'd3, 5'd2, 3'b101, 5'd1, R}, 32'hF000_0000, 32'h24, 0, 4'h7,
                32'hF000_0000, 4, 1, 6'b110000};

    reset = 1; id_valid = 0; id_instr = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; stall_in = 0; flush = 0; alu_result = 0; mem_rd = 0; mem_regwrite = 0;
    mem_result = 0; wb_rd = 0; wb_regwrite = 0; wb_result = 0;
    mdl = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", 128'(obs()), 128'(ex_t'('0)));
    @(negedge clk);
    reset = 0;

    // Directed table, each vector behind a bubble so nothing forwards.
    for (int i = 0; i < 15; i++) begin
      id_valid = 0;
      step();
      drive(tbl[i].instr, tbl[i].rs1d, tbl[i].rs2d, tbl[i].imm);
      id_pc = 9'(i);
      step();
      cmp($sformatf("vec%0d", i),
          128'({ex_valid, ex_operation, ex_src_a, ex_src_b, ex_rd, ex_regwrite, ex_memread,
                ex_memwrite, ex_branch, ex_illegal}),
          128'({tbl[i].fl[5], tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].fl[4:0]}));
    end

    // EX result beats MEM result for the same register.
    drive({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, R}, 7, 9, 0);
    step();
    drive({12'd1, 5'd3, 3'b000, 5'd5, I}, 0, 0, 1);
    alu_result = 32'hFFFF_FFFE; mem_rd = 3; mem_regwrite = 1; mem_result = 99;
    step();
    cmp("fwd_ex_over_mem_a", 128'(ex_src_a), 128'(32'hFFFF_FFFE));
    cmp("fwd_ex_over_mem_b", 128'(ex_src_b), 128'(32'd1));

    // Load-use: one stall cycle with a bubble, then the load value arrives from MEM.
    mem_regwrite = 0; mem_rd = 0;
    drive({12'd0, 5'd1, 3'b010, 5'd4, LD}, 100, 0, 0);
    step();
    drive({7'b0, 5'd4, 5'd4, 3'b000, 5'd6, R}, 0, 0, 0);
    step();
    cmp("loaduse_stall", 128'({pre_hz, pre_rdy}), 128'(2'b10));
    cmp("loaduse_bubble", 128'(ex_valid), 128'(1'b0));
    mem_rd = 4; mem_regwrite = 1; mem_result = 32'h55;
    step();
    cmp("loaduse_release", 128'(pre_hz), 128'(1'b0));
    cmp("loaduse_operands", 128'({ex_src_a, ex_src_b, ex_rd}), 128'({32'h55, 32'h55, 5'd6}));
    mem_regwrite = 0;

    // Flush beats stall_in.
    drive({7'b0, 5'd2, 5'd1, 3'b000, 5'd7, R}, 1, 2, 0);
    step();
    flush = 1; stall_in = 1;
    step();
    cmp("flush_over_stall", 128'(obs()), 128'(ex_t'('0)));
    flush = 0; stall_in = 0;

    // stall_in holds EX, then an async reset clears it before the next edge.
    drive({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, R}, 7, 9, 0);
    step();
    stall_in = 1;
    drive({20'h00001, 5'd9, LU}, 0, 0, 32'h1000);
    step();
    cmp("stall_hold", 128'({ex_operation, ex_src_a, ex_rd}), 128'({4'hF, 32'd7, 5'd3}));
    #2;
    reset = 1;
    #1;
    cmp("async_reset_op", 128'(ex_operation), 128'(4'b0000));
    cmp("async_reset_all", 128'(obs()), 128'(ex_t'('0)));
    @(negedge clk);
    reset = 0; stall_in = 0; mdl = '0;

    for (int n = 0; n < 800; n++) rand_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
